// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the CPU byte bus.
// Holds the byte RAM (1-cycle read latency, 0-cycle write) and decodes the
// I/O window at cpu_a[17:16]==2'b11 (UART rx/tx bytes, cycle counter,
// program stop). 0x20000-0x2FFFF is an unmapped hole.
//
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   cpu_a/cpu_wr/cpu_dout  CPU address, write strobe, write data
//   cpu_din            registered read data to the CPU
//   cpu_rdy            low while the tx FIFO is full (combinational)
//   rx_valid/rx_data   UART receive byte; rx_ack pulses when it is consumed
//   tx_valid/tx_data   tx FIFO head; popped when tx_ready is high
//   prog_stop          sticky, set by a write to 0x30004
//   tx_overflow        sticky, a push was dropped on a full FIFO
module mem_io_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ack,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int unsigned RAM_BYTES = 2 ** ADDR_WIDTH;
  localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  // Storage (not reset)
  logic [7:0] ram_q  [RAM_BYTES];
  logic [7:0] fifo_q [TX_DEPTH];

  // Registered state
  logic [7:0]       cpu_din_q, cpu_din_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      snap_q, snap_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stop_q, stop_d;
  logic             ovf_q, ovf_d;

  // Address decode
  logic                  is_ram, is_io;
  logic [15:0]           io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  unused_cpu_a;

  assign is_ram       = (cpu_a[17] == 1'b0);
  assign is_io        = (cpu_a[17:16] == 2'b11);
  assign io_off       = cpu_a[15:0];
  assign ram_idx      = cpu_a[ADDR_WIDTH-1:0];
  assign unused_cpu_a = ^cpu_a[31:18];

  // Bus-side requests decoded this cycle
  logic       push, pop, full, push_ok;
  logic [7:0] push_data;
  logic       stop_set;

  assign full    = (count_q == CNT_W'(TX_DEPTH));
  assign pop     = (count_q != '0) && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  // Read mux and I/O side effects
  always_comb begin
    cpu_din_d = cpu_din_q;
    snap_d    = snap_q;
    push      = 1'b0;
    push_data = 8'h00;
    stop_set  = 1'b0;
    if (!cpu_wr) begin
      cpu_din_d = 8'h00;
      if (is_ram) begin
        cpu_din_d = ram_q[ram_idx];
      end else if (is_io) begin
        case (io_off)
          16'h0000: cpu_din_d = rx_valid ? rx_data : 8'h00;
          16'h0004: begin
            snap_d    = cyc_q;
            cpu_din_d = cyc_q[7:0];
          end
          16'h0005: cpu_din_d = snap_q[15:8];
          16'h0006: cpu_din_d = snap_q[23:16];
          16'h0007: cpu_din_d = snap_q[31:24];
          default:  cpu_din_d = 8'h00;
        endcase
      end
    end else if (is_io) begin
      case (io_off)
        16'h0000: begin
          // A zero byte is treated as "nothing to send".
          push      = (cpu_dout != 8'h00);
          push_data = cpu_dout;
        end
        16'h0004: begin
          // Stop marker: always queue a 0x00 so the host sees the end.
          push      = 1'b1;
          push_data = 8'h00;
          stop_set  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FIFO bookkeeping and sticky flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    stop_d   = stop_q | stop_set;
    ovf_d    = ovf_q | (push && !push_ok);
    cyc_d    = cyc_q + 32'd1;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_din_q <= 8'h00;
      cyc_q     <= 32'h0;
      snap_q    <= 32'h0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      stop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cpu_din_q <= cpu_din_d;
      cyc_q     <= cyc_d;
      snap_q    <= snap_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      stop_q    <= stop_d;
      ovf_q     <= ovf_d;
    end
  end

  // RAM write port
  always_ff @(posedge clk_in) begin
    if (!rst_in && cpu_wr && is_ram) ram_q[ram_idx] <= cpu_dout;
  end

  // FIFO write port
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_ok) fifo_q[wr_ptr_q] <= push_data;
  end

  assign cpu_din     = cpu_din_q;
  assign cpu_rdy     = !full;
  // Ack in the same cycle so back-to-back reads each take a fresh byte.
  assign rx_ack      = !rst_in && !cpu_wr && is_io && (io_off == 16'h0000) && rx_valid;
  assign tx_valid    = (count_q != '0);
  assign tx_data     = fifo_q[rd_ptr_q];
  assign prog_stop   = stop_q;
  assign tx_overflow = ovf_q;

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU byte bus (address, data-out, data-in, write strobe). It is the far end of what the CPU's memory controller drives.
- Contains the byte RAM with 1-cycle read latency and 0-cycle write.
- Decodes the I/O window at address[17:16]==2'b11: UART input byte, UART output byte, cycle counter and program-stop.
- Used as the simulation/FPGA memory model and as the I/O glue that sits in front of the UART.

Parameters:
- ADDR_WIDTH, 17, RAM holds 2**ADDR_WIDTH bytes; RAM index is cpu_a[ADDR_WIDTH-1:0].
- TX_DEPTH, 8, output FIFO entries; must be a power of two, at least 2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- cpu_a  input  32  byte address from CPU; only bits 17:0 are decoded
- cpu_wr  input  1  1 = write this cycle, 0 = read
- cpu_dout  input  8  write data from CPU
- cpu_din  output  8  read data to CPU, registered
- cpu_rdy  output  1  low when the tx FIFO is full; CPU pauses
- rx_valid  input  1  UART receive byte available
- rx_data  input  8  UART receive byte
- rx_ack  output  1  one-cycle pulse; the rx byte was consumed
- tx_valid  output  1  tx FIFO non-empty
- tx_data  output  8  tx FIFO head byte
- tx_ready  input  1  UART transmitter accepts head byte
- prog_stop  output  1  sticky; set by a write to 0x30004
- tx_overflow  output  1  sticky; a push was dropped because the FIFO was full

Behaviour:
- Reset (rst_in high at posedge): cpu_din=0, rx_ack=0, FIFO empty (tx_valid=0), prog_stop=0, tx_overflow=0, cycle counter=0, snapshot=0. RAM contents are not reset. Reset wins over every simultaneous event.
- Decode:
  - io = cpu_a[17:16]==2'b11.
  - ram = cpu_a[17]==0.
  - Addresses 0x20000-0x2FFFF are a hole: reads return 0, writes are ignored.
- Cycle counter: increments by 1 every cycle after reset, wraps 0xFFFFFFFF->0, never stalls.
- RAM read:
  - The address presented in cycle N gives ram[addr] on cpu_din from cycle N+1.
  - cpu_din is updated every cycle a read is presented.
- RAM write: when cpu_wr=1, ram[addr]<=cpu_dout at the posedge; cpu_din holds its previous value.
- Read-after-write to the same address on the next cycle returns the new byte.
- IO read 0x30000 (low two bits 00, bit 2 = 0):
  - If rx_valid: cpu_din<=rx_data and rx_ack=1 for exactly that cycle.
  - Else: cpu_din<=0 and no ack.
  - Consecutive cycles on the same address each consume one byte.
- IO read 0x30004:
  - snapshot<=counter.
  - cpu_din<=counter[7:0].
- IO reads 0x30005/6/7: return snapshot[15:8]/[23:16]/[31:24], giving a coherent 32-bit read when bytes are read in ascending order.
- IO reads 0x30001-3: return 0.
- IO write 0x30000: push cpu_dout if nonzero; 0x00 is ignored.
- IO write 0x30004: set prog_stop and push 0x00, bypassing the zero filter. Writes to 0x30005-7 are ignored.
- Other IO offsets: reads return 0, writes are ignored.
- tx FIFO:
  - Pop when tx_valid && tx_ready.
  - tx_data is the head entry and is stable while tx_valid && !tx_ready.
  - Push and pop in the same cycle:
    - When full: both happen; the count is unchanged and the push is accepted.
    - When empty: only the push happens; the byte appears on tx_valid the next cycle (no bypass).
  - Push when full without a pop: byte dropped, tx_overflow<=1.
  - cpu_rdy = !full, combinational from the count.
  - Pointers wrap modulo TX_DEPTH; the count is held in log2(TX_DEPTH)+1 bits.
- Reset in the middle of a multi-byte counter read or while the FIFO is draining: all state clears, and the next read of 0x30005 returns 0.

Test Plan:
- Write 0xAB to 0x00010, then read 0x00010 on the next cycle -> cpu_din==0xAB one cycle after the read address. Read 0x1FFFF after writing 0x5C there -> 0x5C.
- rx_valid=1, rx_data=0x41, read 0x30000 -> rx_ack pulses for 1 cycle and cpu_din==0x41. With rx_valid=0 -> cpu_din==0x00 and no ack.
- Release reset; at counter=0x000001FF read 0x30004, then 0x30005/6/7 on later cycles -> bytes 0xFF, 0x01, 0x00, 0x00 regardless of elapsed cycles.
- tx_ready=0, write 0x31..0x38 to 0x30000 (8 writes) -> cpu_rdy falls after the 8th. A 9th write sets tx_overflow. Then raise tx_ready -> tx_data drains 0x31..0x38 in order, and cpu_rdy rises after the first pop.
- Write 0x00 to 0x30000 -> no push. Write any byte to 0x30004 -> prog_stop=1 and tx_data==0x00 valid the next cycle.
- Full FIFO with tx_ready=1 and a simultaneous write of 0x7A -> count stays at 8, no overflow, and 0x7A emerges last. Assert rst_in mid-drain -> tx_valid=0, prog_stop=0, cpu_din=0 the next cycle.
